ntt_ctrl: RTL
=============

Name: ntt_ctrl

Overview:
- Sequencer that drives the single-cycle butterfly across a full 256-point NTT/INTT held in coefficient RAM.
- Issues coefficient-pair read addresses and twiddle ROM indices to the butterfly input side.
- Returns write-back addresses and enables to the butterfly output side, delayed to match the memory-plus-butterfly pipeline.
- Supports forward Cooley-Tukey and inverse Gentleman-Sande modes, each with Dilithium or Kyber stage counts.

Parameters:
PIPE_LAT, 3, cycles from rd_en_o issue to matching wr_en_o (RAM read latency + butterfly register stages); legal range 1..8

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
start_i  input  1  start pulse; sampled only in IDLE
sel_butterfly_i  input  1  0 forward CT, 1 inverse GS; latched at start
sel_red_i  input  1  0 Dilithium, 1 Kyber; latched at start
stall_i  input  1  suppresses new issue while high
rd_en_o  output  1  pair read request
rd_addr_a_o  output  8  address of a
rd_addr_b_o  output  8  address of b
tw_idx_o  output  8  twiddle ROM index, valid with rd_en_o
wr_en_o  output  1  pair write-back
wr_addr_a_o  output  8  write address for a_o
wr_addr_b_o  output  8  write address for b_o
bf_sel_butterfly_o  output  1  latched mode to butterfly
bf_sel_red_o  output  1  latched reduction select to butterfly
stage_o  output  3  current stage, 0-based
busy_o  output  1  high from the cycle after start until done
done_o  output  1  one-cycle pulse at completion

Behaviour:
- Reset: all outputs 0, state IDLE, counters and delay line cleared. Reset mid-operation aborts immediately; no further wr_en_o.
- States: IDLE -> ISSUE on start_i. ISSUE -> DRAIN after 128 issues. DRAIN -> ISSUE (next stage) after PIPE_LAT cycles, or -> DONE after the last stage. DONE -> IDLE after one cycle, with done_o=1 in DONE.
- start_i is ignored outside IDLE. The mode latches are unchanged while busy.
- Stage count: 8 for Dilithium, 7 for Kyber.
- Forward CT, stage s: len=128>>s.
- Inverse GS, stage s: len=1<<s for Dilithium, 2<<s for Kyber.
- Issue counter i runs 0..127 and advances only when rd_en_o=1.
  - j = i & (len-1); g = i >> log2(len).
  - a = (g << (log2(len)+1)) | j; b = a + len.
- Twiddle index:
  - CT: tw_idx_o = (1<<s) + g.
  - GS Dilithium: tw_idx_o = (256>>s) - 1 - g.
  - GS Kyber: tw_idx_o = (128>>s) - 1 - g.
- rd_en_o = (state==ISSUE) && !stall_i. Addresses and tw_idx_o hold their values while stalled.
- Delay line: a PIPE_LAT-deep shift register of {en, addr_a, addr_b}. It always advances and is not affected by stall_i.
  - wr_en_o at cycle t+PIPE_LAT equals rd_en_o at cycle t, with the same addresses.
- DRAIN guarantees that every stage-s write completes before any stage s+1 read, so no RAW hazard exists.
- Unstalled timing: busy_o spans stages*(128+PIPE_LAT)+1 cycles. With PIPE_LAT=3 this is 1049 cycles for Dilithium and 918 for Kyber.
- stage_o increments on DRAIN->ISSUE and returns to 0 in IDLE.

Optional Feature:
- Macro NTT_CTRL_PERF_EN.
- When defined: adds output cycle_cnt_o (16 bits).
  - Clears on accepted start.
  - Increments every cycle busy_o=1.
  - Holds after done until the next start.
  - Reset value 0.
- When undefined: the port and counter are absent.

Test Plan:
- Reset held with start_i=1 -> all outputs 0, no rd_en_o.
- Dilithium CT, PIPE_LAT=3:
  - Cycle 1 after start: rd_addr 0/128, tw 1.
  - Issue 127: addr 127/255, tw 1.
  - Stage 1, first issue: addr 0/64, tw 2.
  - Stage 1, issue 64: addr 128/192, tw 3.
  - Stage 7, issue 127: addr 254/255, tw 255.
  - done_o once, busy 1049 cycles.
- Kyber GS:
  - Stage 0, first: addr 0/2, tw 127; second: addr 1/3, tw 127; third: addr 4/6, tw 126.
  - Stage 6, first: addr 0/128, tw 1.
  - Exactly 7 stages, busy 918 cycles.
- Write-back check: every wr_en_o pair equals the rd pair issued exactly 3 cycles earlier; no write in the cycle a new stage issues its first read.
- stall_i high for 5 cycles mid-stage -> rd_en_o=0 and addresses held; in-flight writes still appear; total busy extends by exactly 5.
- Reset asserted at cycle 200 -> outputs 0 next cycle; start_i pulsed mid-run (no reset) -> ignored, sequence unchanged.

Source files
------------

// File: rtl/ntt_ctrl.sv
// Address/twiddle sequencer for a 256-point NTT/INTT on a single-cycle butterfly.
// Optional macro NTT_CTRL_PERF_EN adds a 16-bit busy-cycle counter output.
module ntt_ctrl #(
  parameter int PIPE_LAT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       sel_butterfly_i,
  input  logic       sel_red_i,
  input  logic       stall_i,
  output logic       rd_en_o,
  output logic [7:0] rd_addr_a_o,
  output logic [7:0] rd_addr_b_o,
  output logic [7:0] tw_idx_o,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_a_o,
  output logic [7:0] wr_addr_b_o,
  output logic       bf_sel_butterfly_o,
  output logic       bf_sel_red_o,
  output logic [2:0] stage_o,
`ifdef NTT_CTRL_PERF_EN
  output logic [15:0] cycle_cnt_o,
`endif
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  typedef struct packed {
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
  } wb_t;

  localparam logic [3:0] DRAIN_END = 4'(PIPE_LAT - 1);

  state_t     state, nxt;
  logic [6:0] idx;
  logic [2:0] stage;
  logic [3:0] drain_cnt;
  logic       mode_bf, mode_red;
  logic [2:0] lg;
  logic [7:0] i8, mask, j, g, a, b, tw;
  logic [2:0] last_stage;
  wb_t        pipe [PIPE_LAT];

  assign last_stage = mode_red ? 3'd6 : 3'd7;

  // Butterfly span as log2(len): CT shrinks from 128, GS grows from 1 (Dilithium) or 2 (Kyber).
  always_comb begin
    lg = 3'd0;
    if (!mode_bf)      lg = 3'd7 - stage;
    else if (mode_red) lg = stage + 3'd1;
    else               lg = stage;
    i8   = {1'b0, idx};
    mask = (8'd1 << lg) - 8'd1;
    j    = i8 & mask;
    g    = i8 >> lg;
    a    = (g << ({1'b0, lg} + 4'd1)) | j;
    b    = a + (8'd1 << lg);
    if (!mode_bf)      tw = (8'd1 << stage) + g;
    else if (mode_red) tw = (8'h7f >> stage) - g;
    else               tw = (8'hff >> stage) - g;
  end

  always_comb begin
    nxt         = state;
    rd_en_o     = 1'b0;
    rd_addr_a_o = 8'd0;
    rd_addr_b_o = 8'd0;
    tw_idx_o    = 8'd0;
    busy_o      = (state != IDLE);
    done_o      = 1'b0;
    case (state)
      IDLE:  if (start_i) nxt = ISSUE;
      ISSUE: begin
        rd_en_o     = !stall_i;
        rd_addr_a_o = a;
        rd_addr_b_o = b;
        tw_idx_o    = tw;
        if (!stall_i && idx == 7'd127) nxt = DRAIN;
      end
      DRAIN: if (drain_cnt == DRAIN_END) nxt = (stage == last_stage) ? DONE : ISSUE;
      DONE: begin
        done_o = 1'b1;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      idx       <= 7'd0;
      stage     <= 3'd0;
      drain_cnt <= 4'd0;
      mode_bf   <= 1'b0;
      mode_red  <= 1'b0;
    end else begin
      state     <= nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
      if (rd_en_o) idx <= idx + 7'd1;
      if (state == IDLE && start_i) begin
        mode_bf  <= sel_butterfly_i;
        mode_red <= sel_red_i;
        stage    <= 3'd0;
        idx      <= 7'd0;
      end
      if (state == DRAIN && nxt == ISSUE) stage <= stage + 3'd1;
      if (state == DONE) stage <= 3'd0;
    end
  end

  // Write-back delay line runs freely so in-flight pairs drain through stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < PIPE_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= '{en: rd_en_o, a: rd_addr_a_o, b: rd_addr_b_o};
      for (int k = 1; k < PIPE_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign wr_en_o            = pipe[PIPE_LAT-1].en;
  assign wr_addr_a_o        = pipe[PIPE_LAT-1].a;
  assign wr_addr_b_o        = pipe[PIPE_LAT-1].b;
  assign bf_sel_butterfly_o = mode_bf;
  assign bf_sel_red_o       = mode_red;
  assign stage_o            = stage;

`ifdef NTT_CTRL_PERF_EN
  logic [15:0] cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i)                        cnt <= 16'd0;
    else if (state == IDLE && start_i) cnt <= 16'd0;
    else if (busy_o)                  cnt <= cnt + 16'd1;
  end
  assign cycle_cnt_o = cnt;
`endif

endmodule
